// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared types and constants for the store buffer.
package store_buffer_pkg;

    // Stores and loads are word accesses, so the low address bits never take part in matching.
    localparam int WORD_LSB = 2;

    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_LOAD,
        PORT_DRAIN
    } port_owner_e;

endpackage

// File: rtl/store_buffer.sv
// store_buffer: circular store FIFO between EX/MEM and data memory.
// It drains to memory when no load owns the port and forwards the youngest matching store to loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    input  logic [ADDRESS_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0]    st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [ADDRESS_WIDTH-1:0] ld_addr,
    output logic                     ld_hit,
    output logic [DATA_WIDTH-1:0]    ld_fwd_data,
    output logic                     mem_write_en,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_data_in,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]    data_q [DEPTH];
    logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    port_owner_e              owner;
    logic                     enq, deq;

    assign st_ready = count_q != CW'(DEPTH);
    assign empty    = count_q == '0;
    assign enq      = st_valid && st_ready;

    always_comb begin
        owner        = ld_valid ? PORT_LOAD : (empty ? PORT_IDLE : PORT_DRAIN);
        deq          = owner == PORT_DRAIN;
        mem_write_en = deq;
        mem_addr     = owner == PORT_LOAD ? ld_addr : addr_q[head_q];
        mem_data_in  = data_q[head_q];
        head_d       = deq ? head_q + 1'b1 : head_q;
        tail_d       = enq ? tail_q + 1'b1 : tail_q;
        count_d      = count_q + CW'(enq) - CW'(deq);
    end

    // Scan oldest to youngest so the last match seen is the one closest to tail.
    always_comb begin
        ld_hit      = 1'b0;
        ld_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q &&
                addr_q[head_q + PW'(i)][ADDRESS_WIDTH-1:WORD_LSB] == ld_addr[ADDRESS_WIDTH-1:WORD_LSB]) begin
                ld_hit      = 1'b1;
                ld_fwd_data = data_q[head_q + PW'(i)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and randomized checks of store_buffer against a queue model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_ready;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        ld_hit;
    logic [31:0] ld_fwd_data;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        empty;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    always #5 clk = ~clk;

    store_buffer #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_fwd_data(ld_fwd_data),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .empty(empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [31:0] la);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        ld_valid = lv;
        ld_addr  = la;
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 32'h10);
        rst_n = 1'b0;
        #1;
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", empty); end
        tests++; if (st_ready !== 1'b1) begin fails++; $display("FAIL reset_st_ready got=%b exp=1", st_ready); end
        tests++; if (mem_write_en !== 1'b0) begin fails++; $display("FAIL reset_mem_write_en got=%b exp=0", mem_write_en); end
        tests++; if (ld_hit !== 1'b0) begin fails++; $display("FAIL reset_ld_hit got=%b exp=0", ld_hit); end
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single_store();
        do_reset();
        drive(1, 32'h10, 32'hA5A5A5A5, 0, 0);
        tests++; if (mem_write_en !== 1'b0) begin fails++; $display("FAIL single_no_same_cycle_write got=%b exp=0", mem_write_en); end
        tick();
        drive(0, 0, 0, 0, 0);
        tests++; if (mem_write_en !== 1'b1) begin fails++; $display("FAIL single_we got=%b exp=1", mem_write_en); end
        tests++; if (mem_addr !== 32'h10) begin fails++; $display("FAIL single_addr got=%h exp=00000010", mem_addr); end
        tests++; if (mem_data_in !== 32'hA5A5A5A5) begin fails++; $display("FAIL single_data got=%h exp=a5a5a5a5", mem_data_in); end
        tick();
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL single_empty got=%b exp=1", empty); end
        tests++; if (mem_write_en !== 1'b0) begin fails++; $display("FAIL single_idle_we got=%b exp=0", mem_write_en); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(i * 4), 32'h100 + 32'(i), 1, 32'h200);
            tests++; if (mem_write_en !== 1'b0 || mem_addr !== 32'h200) begin
                fails++; $display("FAIL fill_load_owns_port we=%b addr=%h exp we=0 addr=00000200", mem_write_en, mem_addr);
            end
            tick();
        end
        drive(1, 32'h40, 32'hDEAD, 1, 32'h200);
        tests++; if (st_ready !== 1'b0) begin fails++; $display("FAIL fill_st_ready got=%b exp=0", st_ready); end
        tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tests++; if (mem_write_en !== 1'b1 || mem_addr !== 32'(i * 4) || mem_data_in !== 32'h100 + 32'(i)) begin
                fails++; $display("FAIL fill_drain%0d we=%b addr=%h data=%h exp we=1 addr=%h data=%h",
                                  i, mem_write_en, mem_addr, mem_data_in, i * 4, 32'h100 + i);
            end
            tick();
        end
        tests++; if (empty !== 1'b1 || mem_write_en !== 1'b0) begin
            fails++; $display("FAIL fill_fifth_dropped empty=%b we=%b exp empty=1 we=0", empty, mem_write_en);
        end
    endtask

    task automatic test_forward();
        do_reset();
        drive(1, 32'h20, 32'h1, 1, 32'h100);
        tick();
        drive(1, 32'h20, 32'h2, 1, 32'h100);
        tick();
        drive(0, 0, 0, 1, 32'h22);
        tests++; if (ld_hit !== 1'b1 || ld_fwd_data !== 32'h2) begin
            fails++; $display("FAIL fwd_youngest hit=%b data=%h exp hit=1 data=00000002", ld_hit, ld_fwd_data);
        end
        drive(0, 0, 0, 1, 32'h24);
        tests++; if (ld_hit !== 1'b0 || ld_fwd_data !== 32'h0) begin
            fails++; $display("FAIL fwd_miss hit=%b data=%h exp hit=0 data=00000000", ld_hit, ld_fwd_data);
        end
        drive(1, 32'h30, 32'h3, 1, 32'h30);
        tests++; if (ld_hit !== 1'b0) begin fails++; $display("FAIL fwd_same_cycle_store hit=%b exp=0", ld_hit); end
        tick();
        drive(0, 0, 0, 1, 32'h33);
        tests++; if (ld_hit !== 1'b1 || ld_fwd_data !== 32'h3) begin
            fails++; $display("FAIL fwd_next_cycle hit=%b data=%h exp hit=1 data=00000003", ld_hit, ld_fwd_data);
        end
    endtask

    task automatic test_wraparound();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h40 + 32'(i * 4), 32'hC000 + 32'(i), 0, 0);
            tests++; if (empty !== 1'b1) begin fails++; $display("FAIL wrap_empty_before%0d got=%b exp=1", i, empty); end
            tick();
            drive(0, 0, 0, 0, 0);
            tests++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h40 + 32'(i * 4) || mem_data_in !== 32'hC000 + 32'(i)) begin
                fails++; $display("FAIL wrap_write%0d we=%b addr=%h data=%h exp we=1 addr=%h data=%h",
                                  i, mem_write_en, mem_addr, mem_data_in, 32'h40 + i * 4, 32'hC000 + i);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h80 + 32'(i * 4), 32'h5000 + 32'(i), 1, 32'h300);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        tests++; if (mem_write_en !== 1'b1) begin fails++; $display("FAIL rstmid_draining got=%b exp=1", mem_write_en); end
        rst_n = 1'b0;
        #1;
        tests++; if (mem_write_en !== 1'b0 || empty !== 1'b1) begin
            fails++; $display("FAIL rstmid_async we=%b empty=%b exp we=0 empty=1", mem_write_en, empty);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (mem_write_en !== 1'b0 || empty !== 1'b1) begin
                fails++; $display("FAIL rstmid_stale%0d we=%b empty=%b exp we=0 empty=1", i, mem_write_en, empty);
            end
        end
    endtask

    task automatic test_random();
        ent_t        q[$];
        logic        sv, lv, e_ready, e_we, e_hit;
        logic [31:0] sa, sd, la, e_fwd;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            sv = 1'($urandom_range(0, 1));
            lv = $urandom_range(0, 2) == 0;
            sa = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            la = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            sd = $urandom;
            drive(sv, sa, sd, lv, la);
            e_ready = q.size() != DEPTH;
            e_we    = !lv && q.size() > 0;
            e_hit   = 1'b0;
            e_fwd   = '0;
            foreach (q[i]) if (q[i].a[31:2] == la[31:2]) begin e_hit = 1'b1; e_fwd = q[i].d; end
            tests++; if (st_ready !== e_ready || empty !== (q.size() == 0)) begin
                fails++; $display("FAIL rnd_status%0d ready=%b empty=%b exp ready=%b empty=%b", n, st_ready, empty, e_ready, q.size() == 0);
            end
            tests++; if (mem_write_en !== e_we) begin
                fails++; $display("FAIL rnd_we%0d got=%b exp=%b", n, mem_write_en, e_we);
            end
            tests++; if (ld_hit !== e_hit || ld_fwd_data !== e_fwd) begin
                fails++; $display("FAIL rnd_fwd%0d hit=%b data=%h exp hit=%b data=%h", n, ld_hit, ld_fwd_data, e_hit, e_fwd);
            end
            if (lv) begin
                tests++; if (mem_addr !== la) begin fails++; $display("FAIL rnd_ld_addr%0d got=%h exp=%h", n, mem_addr, la); end
            end else if (e_we) begin
                tests++; if (mem_addr !== q[0].a || mem_data_in !== q[0].d) begin
                    fails++; $display("FAIL rnd_drain%0d addr=%h data=%h exp addr=%h data=%h", n, mem_addr, mem_data_in, q[0].a, q[0].d);
                end
            end
            tick();
            if (e_we) void'(q.pop_front());
            if (sv && e_ready) q.push_back('{a: sa, d: sd});
        end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_fill();
        test_forward();
        test_wraparound();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32, data word width.
REQ-003 Parameter DEPTH, default 4, number of buffer entries; power of two, at least 2.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port st_valid, input, 1 bit: MEM-stage store request this cycle.
REQ-007 Port st_addr, input, ADDRESS_WIDTH: store byte address.
REQ-008 Port st_data, input, DATA_WIDTH: store data.
REQ-009 Port st_ready, output, 1 bit: buffer can accept a store (not full).
REQ-010 Port ld_valid, input, 1 bit: MEM-stage load request this cycle.
REQ-011 Port ld_addr, input, ADDRESS_WIDTH: load byte address.
REQ-012 Port ld_hit, output, 1 bit: load address matches a buffered store.
REQ-013 Port ld_fwd_data, output, DATA_WIDTH: data of the youngest matching entry.
REQ-014 Port mem_write_en, output, 1 bit: write strobe to the data memory.
REQ-015 Port mem_addr, output, ADDRESS_WIDTH: address to the data memory.
REQ-016 Port mem_data_in, output, DATA_WIDTH: write data to the data memory.
REQ-017 Port empty, output, 1 bit: no entries held.

Function
REQ-018 Entries SHALL be held in a circular FIFO with head pointer, tail pointer and count register.
- count range: 0..DEPTH.
- Pointers wrap modulo DEPTH.
REQ-019 Address matching SHALL compare addr[ADDRESS_WIDTH-1:2] only; addr[1:0] is ignored (word access).
REQ-020 st_ready SHALL equal (count != DEPTH), computed from registered count only; it does not depend on a same-cycle drain.
REQ-021 A store SHALL be enqueued at tail on the clock edge when st_valid && st_ready; a store presented while full is dropped, and the pipeline must stall on !st_ready.
REQ-022 The memory port SHALL be owned by the load when ld_valid=1, with mem_addr=ld_addr and mem_write_en=0.
REQ-023 When ld_valid=0 and count>0, the buffer SHALL drain the head entry.
- mem_write_en=1, mem_addr=head addr, mem_data_in=head data, combinationally.
- head and count advance on the same edge.
REQ-024 When the memory port is idle, mem_write_en SHALL be 0, and mem_addr and mem_data_in SHALL present the head entry (don't-care contents).
REQ-025 ld_hit and ld_fwd_data SHALL be combinational over the valid entries.
- The youngest matching entry (closest to tail) wins.
- ld_fwd_data=0 when there is no hit.
- A store enqueued in the same cycle does not participate.
REQ-026 Simultaneous enqueue and drain SHALL leave count unchanged and advance both pointers.
REQ-027 Latency SHALL be: store accepted at edge N is drainable at the earliest in cycle N+1, and is visible to forwarding from cycle N+1.
REQ-028 empty SHALL equal (count == 0).

Reset
REQ-029 While rst_n=0 the block SHALL asynchronously clear head, tail and count.
- Resulting outputs: empty=1, st_ready=1, mem_write_en=0, ld_hit=0.
REQ-030 Entry contents SHALL NOT be reset.
REQ-031 Reset asserted mid-drain SHALL discard all pending stores without a further write.

Structure
REQ-032 No shared package is required; DEPTH-derived pointer width SHALL be a localparam ($clog2(DEPTH)).
REQ-033 The block SHALL be a single module with no sub-module; it sits between the EX/MEM register and the data memory, and its mem_* ports connect directly to that memory's write_en, addr and data_in.

Verification
REQ-034 Reset: rst_n=0 -> empty=1, st_ready=1, mem_write_en=0, ld_hit=0.
REQ-035 Single store then idle: st_addr=0x10, st_data=0xA5A5A5A5, one cycle -> next cycle mem_write_en=1, mem_addr=0x10, mem_data_in=0xA5A5A5A5; following cycle empty=1.
REQ-036 Fill under continuous loads: 4 stores to 0x0,0x4,0x8,0xC while ld_valid=1 -> st_ready=0 after the 4th; a 5th store is not enqueued; releasing ld_valid yields 4 in-order writes.
REQ-037 Forwarding priority: stores 0x20<-0x1, then 0x20<-0x2, held by ld_valid; load ld_addr=0x22 -> ld_hit=1, ld_fwd_data=0x2.
REQ-038 Wrap-around: 10 alternating store/drain cycles with DEPTH=4 -> write order and data match store order exactly; count never exceeds 1.
REQ-039 Reset mid-operation: 3 entries pending, pulse rst_n low between edges -> mem_write_en=0 immediately and empty=1; no stale write after release.
